// File: rtl/bus_master_port_if.sv
`default_nettype none
// ============================================================================
// bus_master_port_if : core request signals plus the bit-serial shared-bus
//                      signals of one master port
// Revision: 1.0
// ============================================================================
interface bus_master_port_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  // Core side
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              err;
  // Bus side
  logic              b_req;
  logic              b_grant;
  logic              b_util;
  logic              a_add;
  logic              b_bus_out;
  logic              b_rw;
  logic              b_done;
  logic              b_bus_in;
  logic              b_ready;
  logic              b_ack;
  logic              b_split;
  logic              b_spl_resume;

  modport master (
    input  start, rw, addr, wdata,
    input  b_grant, b_bus_in, b_ready, b_ack, b_split, b_spl_resume,
    output busy, rdata, done, err,
    output b_req, b_util, a_add, b_bus_out, b_rw, b_done
  );

  modport slave (
    output start, rw, addr, wdata,
    output b_grant, b_bus_in, b_ready, b_ack, b_split, b_spl_resume,
    input  busy, rdata, done, err,
    input  b_req, b_util, a_add, b_bus_out, b_rw, b_done
  );
endinterface
`default_nettype wire

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
// bus_master_port : turns one parallel core read/write into the serial
//                   request/grant/address/data protocol of the shared bus
// Revision: 1.0
// ============================================================================
module bus_master_port #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bus_master_port_if.master bus
);

  localparam int CNT_MAX = (ADDR_W > DATA_W)
                           ? ((ADDR_W > ACK_TIMEOUT) ? ADDR_W : ACK_TIMEOUT)
                           : ((DATA_W > ACK_TIMEOUT) ? DATA_W : ACK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ        = 3'd1,
    S_ADDR       = 3'd2,
    S_ACK_WAIT   = 3'd3,
    S_WR         = 3'd4,
    S_RD         = 3'd5,
    S_SPLIT_WAIT = 3'd6,
    S_FIN        = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resume_q, resume_d;
  logic                err_q, err_d;
  logic                abort;
  logic [DATA_W-1:0]   rx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      resume_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
      err_q    <= err_d;
    end
  end

  // Read bits arrive LSB first, so each new bit enters at the top.
  assign rx_shift = {bus.b_bus_in, rx_q[DATA_W-1:1]};

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;
    err_d    = 1'b0;
    abort    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rw_d     = bus.rw;
          addr_d   = bus.addr;
          wdata_d  = bus.wdata;
          cnt_d    = '0;
          resume_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.b_grant) begin
          cnt_d    = '0;
          resume_d = 1'b0;
          state_d  = resume_q ? S_RD : S_ADDR;
        end
      end
      S_ADDR: begin
        if (!bus.b_grant) begin
          abort = 1'b1;
        end else begin
          addr_d = addr_q >> 1;
          if (cnt_q == C_ADDR_LAST) begin
            cnt_d   = '0;
            state_d = S_ACK_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ACK_WAIT: begin
        if (!bus.b_grant) begin
          abort = 1'b1;
        end else if (bus.b_ack) begin
          cnt_d   = '0;
          state_d = rw_q ? S_WR : S_RD;
        end else if (cnt_q == C_ACK_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        if (!bus.b_grant) begin
          abort = 1'b1;
        end else if (bus.b_ready) begin
          wdata_d = wdata_q >> 1;
          if (cnt_q == C_DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RD: begin
        // A split is only honoured before any data bit has been taken.
        if (!bus.b_grant) begin
          abort = 1'b1;
        end else if (bus.b_split && (cnt_q == '0)) begin
          state_d = S_SPLIT_WAIT;
        end else if (bus.b_ready) begin
          rx_d = rx_shift;
          if (cnt_q == C_DATA_LAST) begin
            rdata_d = rx_shift;
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SPLIT_WAIT: begin
        if (bus.b_spl_resume) begin
          resume_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The error strobe is issued from IDLE so the bus is already released.
    if (abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      resume_d = 1'b0;
      err_d    = 1'b1;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.b_req     = (state_q == S_REQ) || (state_q == S_ADDR) || (state_q == S_ACK_WAIT) ||
                         (state_q == S_WR)  || (state_q == S_RD);
  assign bus.b_util    = (state_q == S_ADDR) || (state_q == S_ACK_WAIT) ||
                         (state_q == S_WR)   || (state_q == S_RD);
  assign bus.a_add     = (state_q == S_ADDR);
  assign bus.b_rw      = bus.b_util & rw_q;
  assign bus.b_bus_out = ((state_q == S_ADDR) & addr_q[0]) | ((state_q == S_WR) & wdata_q[0]);
  assign bus.done      = (state_q == S_FIN);
  assign bus.b_done    = (state_q == S_FIN) | err_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;

endmodule
`default_nettype wire
